hazard_tracker: RTL and testbench
=================================

HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL have port: d_tuse_rs  input  2  D-stage rs use time; 0=Tuse_0, 1=Tuse_1, 2=Tuse_2, 3=Tuse_no.
REQ-004 SHALL have port: d_tuse_rt  input  2  D-stage rt use time, same encoding.
REQ-005 SHALL have port: d_rs  input  5  D-stage rs register index.
REQ-006 SHALL have port: d_rt  input  5  D-stage rt register index.
REQ-007 SHALL have port: d_res  input  3  D-stage result source; 0=RES_NO, 1=RES_ALU, 2=RES_DM, 3=RES_PC, 4-7 treated as RES_NO.
REQ-008 SHALL have port: d_a3  input  5  D-stage destination register index.
REQ-009 SHALL have port: stall  output  1  hold PC/D register, bubble E.
REQ-010 SHALL have port: fwd_rs_sel  output  2  0=register file, 1=E, 2=M, 3=W.
REQ-011 SHALL have port: fwd_rt_sel  output  2  same encoding as fwd_rs_sel.
REQ-012 SHALL have port: stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-013 SHALL keep per-stage records for E, M and W: valid (1b), a3 (5b), tnew (2b).
REQ-014 SHALL load E from D when stall=0: valid=(d_res in 1..3 and d_a3!=0), a3=d_a3, tnew = ALU:1, DM:2, PC:0.
REQ-015 SHALL load E with a bubble (valid=0, a3=0, tnew=0) when stall=1.
REQ-016 SHALL advance E->M and M->W every cycle regardless of stall; tnew decrements by 1 on each advance, saturating at 0.
REQ-017 SHALL define match(stage,r) = stage.valid and stage.a3==r and r!=0.
REQ-018 SHALL assert stall combinationally when, for rs or rt, match(E,r) and tuse<E.tnew, or match(M,r) and tuse<M.tnew; W never causes a stall.
REQ-019 SHALL never stall for tuse=3 (Tuse_no), since tnew<=2.
REQ-020 SHALL compute each fwd_sel from the youngest matching stage (priority E>M>W): its code if its tnew==0, else 0; no match gives 0.
REQ-021 SHALL not forward from an older stage when a younger match exists with tnew>0.
REQ-022 SHALL evaluate rs and rt independently; either side alone may raise stall.
REQ-023 SHALL increment stall_cnt by 1 on each rising edge with stall=1, holding at 16'hFFFF.
REQ-024 SHALL derive stall and fwd_*_sel purely from current stage records and D inputs, with zero cycle latency.

Reset
REQ-025 SHALL, on rising clk with reset=0, clear all stage records (valid=0, a3=0, tnew=0) and clear stall_cnt to 0.
REQ-026 SHALL thus drive stall=0 and fwd_rs_sel=fwd_rt_sel=0 in the cycle after reset, with no D-stage match.
REQ-027 SHALL give reset priority over a simultaneous stall; no stall_cnt increment in a reset cycle.

Verification
REQ-028 SHALL pass: lw $1 (RES_DM, a3=1) then addu rs=1 tuse=1 -> stall=1 for 1 cycle (E.tnew=2); next cycle M.tnew=1, stall=0, fwd_rs_sel=0; stall_cnt=1.
REQ-029 SHALL pass: addu a3=3 (RES_ALU) then beq rs=3 tuse=0 -> stall=1 one cycle; next cycle M.tnew=0, stall=0, fwd_rs_sel=2.
REQ-030 SHALL pass: jal (RES_PC, a3=31) then jr rs=31 tuse=0 -> stall=0, fwd_rs_sel=1.
REQ-031 SHALL pass: writer with d_a3=0 then reader rs=0 tuse=0 -> stall=0, fwd_rs_sel=0.
REQ-032 SHALL pass: reset=0 asserted while stall=1 -> after that edge stall=0, all fwd_sel=0, stall_cnt=0.
REQ-033 SHALL pass: sw rt=5 tuse=2 behind lw a3=5 in E -> stall=0 (2 not < 2); E then holds sw, not a bubble.

Source files
------------

// File: rtl/hazard_tracker.sv
// Stall and forwarding control for a 5-stage pipeline: tracks E/M/W destination
// records and compares them with the D-stage operand use times.
module hazard_tracker (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  d_tuse_rs,
   input  logic [1:0]  d_tuse_rt,
   input  logic [4:0]  d_rs,
   input  logic [4:0]  d_rt,
   input  logic [2:0]  d_res,
   input  logic [4:0]  d_a3,
   output logic        stall,
   output logic [1:0]  fwd_rs_sel,
   output logic [1:0]  fwd_rt_sel,
   output logic [15:0] stall_cnt
);

   localparam logic [2:0] RES_ALU = 3'd1;
   localparam logic [2:0] RES_DM  = 3'd2;
   localparam logic [2:0] RES_PC  = 3'd3;

   logic       r_e_vld, r_m_vld, r_w_vld;
   logic [4:0] r_e_a3,  r_m_a3,  r_w_a3;
   logic [1:0] r_e_tnew, r_m_tnew, r_w_tnew;
   logic [15:0] r_stall_cnt;

   logic       w_d_vld;
   logic [1:0] w_d_tnew;
   logic       w_rs_e, w_rs_m, w_rs_w, w_rt_e, w_rt_m, w_rt_w;
   logic       w_stall_rs, w_stall_rt;

   always_comb begin
      w_d_tnew = 2'd0;
      case (d_res)
         RES_ALU: w_d_tnew = 2'd1;
         RES_DM:  w_d_tnew = 2'd2;
         default: w_d_tnew = 2'd0;
      endcase
   end

   assign w_d_vld = (d_res == RES_ALU || d_res == RES_DM || d_res == RES_PC) && (d_a3 != 5'd0);

   assign w_rs_e = r_e_vld && (r_e_a3 == d_rs) && (d_rs != 5'd0);
   assign w_rs_m = r_m_vld && (r_m_a3 == d_rs) && (d_rs != 5'd0);
   assign w_rs_w = r_w_vld && (r_w_a3 == d_rs) && (d_rs != 5'd0);
   assign w_rt_e = r_e_vld && (r_e_a3 == d_rt) && (d_rt != 5'd0);
   assign w_rt_m = r_m_vld && (r_m_a3 == d_rt) && (d_rt != 5'd0);
   assign w_rt_w = r_w_vld && (r_w_a3 == d_rt) && (d_rt != 5'd0);

   // Tuse_no (3) can never be below a tnew of at most 2, so it never stalls.
   assign w_stall_rs = (w_rs_e && (d_tuse_rs < r_e_tnew)) || (w_rs_m && (d_tuse_rs < r_m_tnew));
   assign w_stall_rt = (w_rt_e && (d_tuse_rt < r_e_tnew)) || (w_rt_m && (d_tuse_rt < r_m_tnew));
   assign stall      = w_stall_rs || w_stall_rt;

   // Youngest match wins; a younger producer still in flight blocks older ones.
   function automatic logic [1:0] fwd_sel(input logic me, input logic mm, input logic mw,
                                          input logic [1:0] te, input logic [1:0] tm,
                                          input logic [1:0] tw);
      if (me)      fwd_sel = (te == 2'd0) ? 2'd1 : 2'd0;
      else if (mm) fwd_sel = (tm == 2'd0) ? 2'd2 : 2'd0;
      else if (mw) fwd_sel = (tw == 2'd0) ? 2'd3 : 2'd0;
      else         fwd_sel = 2'd0;
   endfunction

   assign fwd_rs_sel = fwd_sel(w_rs_e, w_rs_m, w_rs_w, r_e_tnew, r_m_tnew, r_w_tnew);
   assign fwd_rt_sel = fwd_sel(w_rt_e, w_rt_m, w_rt_w, r_e_tnew, r_m_tnew, r_w_tnew);
   assign stall_cnt  = r_stall_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_e_vld     <= 1'b0;  r_e_a3 <= 5'd0;  r_e_tnew <= 2'd0;
         r_m_vld     <= 1'b0;  r_m_a3 <= 5'd0;  r_m_tnew <= 2'd0;
         r_w_vld     <= 1'b0;  r_w_a3 <= 5'd0;  r_w_tnew <= 2'd0;
         r_stall_cnt <= 16'd0;
      end else begin
         if (stall) begin
            r_e_vld  <= 1'b0;
            r_e_a3   <= 5'd0;
            r_e_tnew <= 2'd0;
         end else begin
            r_e_vld  <= w_d_vld;
            r_e_a3   <= d_a3;
            r_e_tnew <= w_d_tnew;
         end
         r_m_vld  <= r_e_vld;
         r_m_a3   <= r_e_a3;
         r_m_tnew <= (r_e_tnew == 2'd0) ? 2'd0 : r_e_tnew - 2'd1;
         r_w_vld  <= r_m_vld;
         r_w_a3   <= r_m_a3;
         r_w_tnew <= (r_m_tnew == 2'd0) ? 2'd0 : r_m_tnew - 2'd1;
         if (stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed pipeline scenarios followed by random traffic, all checked against an
// in-flight instruction model that derives readiness from latency and age.
module tb_hazard_tracker;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  d_tuse_rs, d_tuse_rt;
   logic [4:0]  d_rs, d_rt, d_a3;
   logic [2:0]  d_res;
   logic        stall;
   logic [1:0]  fwd_rs_sel, fwd_rt_sel;
   logic [15:0] stall_cnt;

   int n_chk = 0;
   int n_fail = 0;

   // Model: slot 0=E, 1=M, 2=W; result ready once age reaches latency.
   bit m_vld [3];
   int m_a3  [3];
   int m_lat [3];
   int m_age [3];
   int m_cnt;

   // Pre-edge samples of the last cycle.
   logic       s_stall;
   logic [1:0] s_rs, s_rt;
   logic [15:0] s_cnt;

   hazard_tracker dut (
      .clk(clk), .reset(reset), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
      .d_rs(d_rs), .d_rt(d_rt), .d_res(d_res), .d_a3(d_a3),
      .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int ready_in(int s);
      int t;
      t = m_lat[s] - m_age[s];
      return (t < 0) ? 0 : t;
   endfunction

   function automatic bit hit(int s, int r);
      return m_vld[s] && m_a3[s] == r && r != 0;
   endfunction

   function automatic bit exp_stall_side(int r, int tuse);
      for (int s = 0; s < 2; s++)
         if (hit(s, r) && tuse < ready_in(s)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int exp_fwd(int r);
      for (int s = 0; s < 3; s++)
         if (hit(s, r)) return (ready_in(s) == 0) ? s + 1 : 0;
      return 0;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 3; s++) begin
         m_vld[s] = 0; m_a3[s] = 0; m_lat[s] = 0; m_age[s] = 0;
      end
      m_cnt = 0;
   endtask

   task automatic cycle(input bit rst_n, input int res, input int a3,
                        input int rs, input int tuse_rs, input int rt, input int tuse_rt);
      bit e_st;
      @(negedge clk);
      reset = rst_n; d_res = 3'(res); d_a3 = 5'(a3);
      d_rs = 5'(rs); d_tuse_rs = 2'(tuse_rs); d_rt = 5'(rt); d_tuse_rt = 2'(tuse_rt);
      #1;
      e_st = exp_stall_side(rs, tuse_rs) || exp_stall_side(rt, tuse_rt);
      s_stall = stall; s_rs = fwd_rs_sel; s_rt = fwd_rt_sel; s_cnt = stall_cnt;
      chk("stall", int'(stall), int'(e_st));
      chk("fwd_rs", int'(fwd_rs_sel), exp_fwd(rs));
      chk("fwd_rt", int'(fwd_rt_sel), exp_fwd(rt));
      chk("stall_cnt", int'(stall_cnt), m_cnt);
      @(posedge clk);
      if (!rst_n) model_reset();
      else begin
         for (int s = 2; s > 0; s--) begin
            m_vld[s] = m_vld[s-1]; m_a3[s] = m_a3[s-1];
            m_lat[s] = m_lat[s-1]; m_age[s] = m_age[s-1] + 1;
         end
         m_vld[0] = !e_st && (res >= 1 && res <= 3) && a3 != 0;
         m_a3[0]  = e_st ? 0 : a3;
         m_lat[0] = (res == 1) ? 1 : (res == 2) ? 2 : 0;
         m_age[0] = 0;
         if (e_st && m_cnt < 65535) m_cnt++;
      end
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 3, 0, 3);
   endtask

   initial begin
      model_reset();
      reset = 0; d_res = 0; d_a3 = 0; d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3;
      repeat (2) @(posedge clk);
      cycle(0, 0, 0, 0, 3, 0, 3);
      cycle(1, 0, 0, 1, 0, 2, 0);
      chk("rst_stall", int'(s_stall), 0);
      chk("rst_cnt", int'(s_cnt), 0);

      // lw $1 then dependent addu
      cycle(1, 2, 1, 0, 3, 0, 3);
      cycle(1, 1, 2, 1, 1, 0, 3);
      chk("lw_addu_stall", int'(s_stall), 1);
      cycle(1, 1, 2, 1, 1, 0, 3);
      chk("lw_addu_release", int'(s_stall), 0);
      chk("lw_addu_fwd", int'(s_rs), 0);
      chk("lw_addu_cnt", int'(s_cnt), 1);
      nop(3);

      // addu $3 then beq on $3
      cycle(1, 1, 3, 0, 3, 0, 3);
      cycle(1, 0, 0, 3, 0, 0, 3);
      chk("addu_beq_stall", int'(s_stall), 1);
      cycle(1, 0, 0, 3, 0, 0, 3);
      chk("addu_beq_release", int'(s_stall), 0);
      chk("addu_beq_fwd", int'(s_rs), 2);
      nop(3);

      // jal then jr $31
      cycle(1, 3, 31, 0, 3, 0, 3);
      cycle(1, 0, 0, 31, 0, 0, 3);
      chk("jal_jr_stall", int'(s_stall), 0);
      chk("jal_jr_fwd", int'(s_rs), 1);
      nop(3);

      // writer to $0 never forwards
      cycle(1, 1, 0, 0, 3, 0, 3);
      cycle(1, 0, 0, 0, 0, 0, 0);
      chk("zero_stall", int'(s_stall), 0);
      chk("zero_fwd", int'(s_rs), 0);
      nop(3);

      // reset while stalling
      cycle(1, 2, 1, 0, 3, 0, 3);
      cycle(0, 1, 2, 1, 0, 0, 3);
      chk("rst_during_stall", int'(s_stall), 1);
      cycle(1, 0, 0, 1, 0, 1, 0);
      chk("post_rst_stall", int'(s_stall), 0);
      chk("post_rst_fwd_rs", int'(s_rs), 0);
      chk("post_rst_fwd_rt", int'(s_rt), 0);
      chk("post_rst_cnt", int'(s_cnt), 0);

      // sw rt=5 tuse=2 behind lw $5
      cycle(1, 2, 5, 0, 3, 0, 3);
      cycle(1, 0, 0, 0, 3, 5, 2);
      chk("sw_lw_stall", int'(s_stall), 0);
      cycle(1, 0, 0, 0, 3, 5, 1);
      chk("sw_lw_m_tuse1", int'(s_stall), 0);
      nop(3);

      for (int i = 0; i < 600; i++)
         cycle(($urandom_range(39) != 0), $urandom_range(7), $urandom_range(3),
               $urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
